operand_loader: RTL

Front-end stage that feeds the 10-bit ripple-carry adder on the UPduino 3.1. It synchronizes and debounces one push-button, then uses a three-state FSM to capture the slide-switch word first as operand A and then as operand B with carry-in. It holds both operands and the carry-in stable at the adder inputs and flags when a complete operand set is present. The adder stays purely combinational; this block owns all sequencing and button handling.

---
 rtl/operand_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// operand_loader: button-driven operand capture for a combinational adder.
// Syncs/debounces btn, then a 3-state FSM loads A, then B and Cin.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   sw             raw switch word, captured as A or B
//   sw_cin         raw carry-in switch, captured with B
//   btn            raw bouncy push-button, active-high
//   A, B, Cin      held operands for the adder
//   operands_valid high while a full operand set is shown
//   state_led      state code: LOAD_A=00, LOAD_B=01, SHOW=10
module operand_loader #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             sw_cin,
    input  logic             btn,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    output logic             operands_valid,
    output logic [1:0]       state_led
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    state_t        state;
    logic          btn_m;
    logic          btn_s;
    logic          btn_db;
    logic          btn_db_q;
    logic [CW-1:0] db_cnt;
    logic          press;

    // Two-flop synchronizer; only btn_s is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
        end
    end

    // A new level is accepted after DEBOUNCE_CYCLES consecutive
    // differing samples; any return to the old level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; release is ignored.
    assign press = btn_db & ~btn_db_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
            A     <= '0;
            B     <= '0;
            Cin   <= 1'b0;
        end else if (press) begin
            unique case (state)
                LOAD_A: begin
                    A     <= sw;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    B     <= sw;
                    Cin   <= sw_cin;
                    state <= SHOW;
                end
                SHOW: begin
                    state <= LOAD_A;
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

    // Decoded straight from the state register: no extra latency.
    always_comb begin
        operands_valid = (state == SHOW);
        state_led      = state;
    end

endmodule
